// File: rtl/mem_wb_stage.sv
// Writeback stage: takes one retiring instruction per handshake, waits on the
// data-memory response for loads, aligns/extends the loaded value and issues
// exactly one register-file write per instruction.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | empty, ready to accept
// ST_WAIT  | load accepted, waiting for dmem_data_ok_i
// ST_WB    | register-file write issued this cycle; may accept the next one
// ST_DRAIN | load was flushed, swallowing its pending memory response
module mem_wb_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic          in_wen_i,
    input  logic [AW-1:0] in_waddr_i,
    input  logic [DW-1:0] in_alu_res_i,
    input  logic          in_is_load_i,
    input  logic [2:0]    in_load_type_i,
    input  logic [1:0]    in_addr_lo_i,
    input  logic [DW-1:0] dmem_rdata_i,
    input  logic          dmem_data_ok_i,
    output logic          rf_we_o,
    output logic [AW-1:0] rf_waddr_o,
    output logic [DW-1:0] rf_wdata_o,
    output logic          load_pending_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WB    = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [2:0] LT_LB  = 3'd0;
    localparam logic [2:0] LT_LBU = 3'd1;
    localparam logic [2:0] LT_LH  = 3'd2;
    localparam logic [2:0] LT_LHU = 3'd3;

    state_t        state_q;
    state_t        state_next;
    logic          accept;

    logic          held_wen;
    logic [AW-1:0] held_waddr;
    logic [2:0]    held_load_type;
    logic [1:0]    held_addr_lo;

    // Output registers are loaded only on entry to ST_WB, so address/data
    // hold their last written values in every other state.
    logic          rf_we_q;
    logic [AW-1:0] rf_waddr_q;
    logic [DW-1:0] rf_wdata_q;

    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [DW-1:0] ld_data;

    assign in_ready_o     = ((state_q == ST_IDLE) || (state_q == ST_WB)) && !flush_i;
    assign accept         = in_valid_i && in_ready_o;
    assign load_pending_o = (state_q == ST_WAIT);
    assign rf_we_o        = rf_we_q;
    assign rf_waddr_o     = rf_waddr_q;
    assign rf_wdata_o     = rf_wdata_q;

    // Select and extend the loaded byte/half according to the held access info.
    always_comb begin
        ld_byte = dmem_rdata_i[7:0];
        case (held_addr_lo)
            2'd0:    ld_byte = dmem_rdata_i[7:0];
            2'd1:    ld_byte = dmem_rdata_i[15:8];
            2'd2:    ld_byte = dmem_rdata_i[23:16];
            default: ld_byte = dmem_rdata_i[31:24];
        endcase
        ld_half = held_addr_lo[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (held_load_type)
            LT_LB:   ld_data = {{(DW-8){ld_byte[7]}}, ld_byte};
            LT_LBU:  ld_data = {{(DW-8){1'b0}}, ld_byte};
            LT_LH:   ld_data = {{(DW-16){ld_half[15]}}, ld_half};
            LT_LHU:  ld_data = {{(DW-16){1'b0}}, ld_half};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    // Next-state decode.
    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE, ST_WB: begin
                if (accept)
                    state_next = in_is_load_i ? ST_WAIT : ST_WB;
                else
                    state_next = ST_IDLE;
            end
            ST_WAIT: begin
                if (flush_i)
                    state_next = dmem_data_ok_i ? ST_IDLE : ST_DRAIN;
                else if (dmem_data_ok_i)
                    state_next = ST_WB;
            end
            ST_DRAIN: begin
                if (dmem_data_ok_i)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, held instruction fields and the write-port registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            held_wen       <= 1'b0;
            held_waddr     <= '0;
            held_load_type <= '0;
            held_addr_lo   <= '0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
        end else begin
            state_q <= state_next;
            rf_we_q <= 1'b0;
            if (accept) begin
                held_wen       <= in_wen_i;
                held_waddr     <= in_waddr_i;
                held_load_type <= in_load_type_i;
                held_addr_lo   <= in_addr_lo_i;
                if (!in_is_load_i) begin
                    rf_we_q    <= in_wen_i && (in_waddr_i != '0);
                    rf_waddr_q <= in_waddr_i;
                    rf_wdata_q <= in_alu_res_i;
                end
            end else if ((state_q == ST_WAIT) && dmem_data_ok_i && !flush_i) begin
                rf_we_q    <= held_wen && (held_waddr != '0);
                rf_waddr_q <= held_waddr;
                rf_wdata_q <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a cycle table for the main datapath plus
// hand-written flush and reset sequences.
module tb_mem_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        in_wen_i;
    logic [4:0]  in_waddr_i;
    logic [31:0] in_alu_res_i;
    logic        in_is_load_i;
    logic [2:0]  in_load_type_i;
    logic [1:0]  in_addr_lo_i;
    logic [31:0] dmem_rdata_i;
    logic        dmem_data_ok_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        load_pending_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    mem_wb_stage #(.DW(32), .AW(5)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_wen_i       (in_wen_i),
        .in_waddr_i     (in_waddr_i),
        .in_alu_res_i   (in_alu_res_i),
        .in_is_load_i   (in_is_load_i),
        .in_load_type_i (in_load_type_i),
        .in_addr_lo_i   (in_addr_lo_i),
        .dmem_rdata_i   (dmem_rdata_i),
        .dmem_data_ok_i (dmem_data_ok_i),
        .rf_we_o        (rf_we_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_wdata_o     (rf_wdata_o),
        .load_pending_o (load_pending_o)
    );

    typedef struct {
        logic        flush;
        logic        valid;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] alu;
        logic        is_load;
        logic [2:0]  ltype;
        logic [1:0]  alo;
        logic [31:0] rdata;
        logic        dok;
        logic        e_rdy;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_pend;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic fl, logic va, logic we, logic [4:0] wa, logic [31:0] alu,
                                logic ld, logic [2:0] lt, logic [1:0] alo, logic [31:0] rd,
                                logic dok, logic e_rdy, logic e_we, logic [4:0] e_wa,
                                logic [31:0] e_wd, logic e_pend);
        vec_t v;
        v.flush = fl;   v.valid = va;  v.wen = we;     v.waddr = wa;  v.alu = alu;
        v.is_load = ld; v.ltype = lt;  v.alo = alo;    v.rdata = rd;  v.dok = dok;
        v.e_rdy = e_rdy; v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd; v.e_pend = e_pend;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step=%0d got=%h want=%h", nm, idx, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i = 0; in_valid_i = 0; in_wen_i = 0; in_waddr_i = 0; in_alu_res_i = 0;
        in_is_load_i = 0; in_load_type_i = 0; in_addr_lo_i = 0; dmem_rdata_i = 0;
        dmem_data_ok_i = 0;
    endtask

    task automatic chk_out(input string nm, input int idx, input logic rdy, input logic we,
                           input logic [4:0] wa, input logic [31:0] wd, input logic pend);
        chk({nm, ".ready"}, idx, 32'(in_ready_o), 32'(rdy));
        chk({nm, ".we"},    idx, 32'(rf_we_o), 32'(we));
        chk({nm, ".waddr"}, idx, 32'(rf_waddr_o), 32'(wa));
        chk({nm, ".wdata"}, idx, rf_wdata_o, wd);
        chk({nm, ".pend"},  idx, 32'(load_pending_o), 32'(pend));
    endtask

    task automatic load_instr(input logic [4:0] wa, input logic [2:0] lt, input logic [1:0] alo);
        idle_inputs();
        in_valid_i = 1; in_is_load_i = 1; in_wen_i = 1; in_waddr_i = wa;
        in_load_type_i = lt; in_addr_lo_i = alo; in_alu_res_i = 32'h0BAD_0BAD;
    endtask

    initial begin
        // cols: flush valid wen waddr alu is_load ltype alo rdata dok | rdy we waddr wdata pend
        vq.push_back(mk(0,0,0, 0,32'h0,        0,0,0,32'h0,0, 1,0, 0,32'h0,0));        // reset state
        vq.push_back(mk(0,1,1, 5,32'h12345678, 0,0,0,32'h0,0, 1,0, 0,32'h0,0));        // accept
        vq.push_back(mk(0,0,0, 0,32'h0,        0,0,0,32'h0,0, 1,1, 5,32'h12345678,0));
        vq.push_back(mk(0,0,0, 0,32'h0,        0,0,0,32'h0,0, 1,0, 5,32'h12345678,0));
        vq.push_back(mk(0,1,1, 1,32'h11,       0,0,0,32'h0,0, 1,0, 5,32'h12345678,0)); // back-to-back
        vq.push_back(mk(0,1,1, 2,32'h22,       0,0,0,32'h0,0, 1,1, 1,32'h11,0));
        vq.push_back(mk(0,1,1, 3,32'h33,       0,0,0,32'h0,0, 1,1, 2,32'h22,0));
        vq.push_back(mk(0,1,1, 4,32'h44,       0,0,0,32'h0,0, 1,1, 3,32'h33,0));
        vq.push_back(mk(0,1,1, 0,32'h55,       0,0,0,32'h0,0, 1,1, 4,32'h44,0));       // waddr 0
        vq.push_back(mk(0,0,0, 0,32'h0,        0,0,0,32'h0,0, 1,0, 0,32'h55,0));
        vq.push_back(mk(0,0,0, 0,32'h0,        0,0,0,32'h0,0, 1,0, 0,32'h55,0));
        vq.push_back(mk(0,1,1, 7,32'hDEAD,     1,0,3,32'h0,0, 1,0, 0,32'h55,0));       // LB alo=3
        vq.push_back(mk(0,1,1, 9,32'h99,       0,0,0,32'h0,0, 0,0, 0,32'h55,1));       // not accepted
        vq.push_back(mk(0,0,0, 0,32'h0,        0,0,0,32'h0,0, 0,0, 0,32'h55,1));
        vq.push_back(mk(0,0,0, 0,32'h0,        0,0,0,32'h80FF00AA,1, 0,0, 0,32'h55,1));
        vq.push_back(mk(0,0,0, 0,32'h0,        0,0,0,32'h0,0, 1,1, 7,32'hFFFFFF80,0));
        vq.push_back(mk(0,0,0, 0,32'h0,        0,0,0,32'h0,0, 1,0, 7,32'hFFFFFF80,0));
        vq.push_back(mk(0,1,1, 8,32'h0,        1,1,3,32'h0,0, 1,0, 7,32'hFFFFFF80,0)); // LBU alo=3
        vq.push_back(mk(0,0,0, 0,32'h0,        0,0,0,32'h80FF00AA,1, 0,0, 7,32'hFFFFFF80,1));
        vq.push_back(mk(0,1,1, 9,32'h0,        1,2,2,32'h0,0, 1,1, 8,32'h00000080,0)); // LH alo=2, accepted in WB
        vq.push_back(mk(0,0,0, 0,32'h0,        0,0,0,32'h8001F00F,1, 0,0, 8,32'h00000080,1));
        vq.push_back(mk(0,1,1,10,32'h0,        1,3,0,32'h0,0, 1,1, 9,32'hFFFF8001,0)); // LHU alo=0
        vq.push_back(mk(0,0,0, 0,32'h0,        0,0,0,32'h8001F00F,1, 0,0, 9,32'hFFFF8001,1));
        vq.push_back(mk(0,1,1,11,32'h0,        1,4,1,32'h0,0, 1,1,10,32'h0000F00F,0)); // LW
        vq.push_back(mk(0,0,0, 0,32'h0,        0,0,0,32'h8001F00F,1, 0,0,10,32'h0000F00F,1));
        vq.push_back(mk(0,1,1,12,32'h0,        1,6,3,32'h0,0, 1,1,11,32'h8001F00F,0)); // type 6 -> LW
        vq.push_back(mk(0,0,0, 0,32'h0,        0,0,0,32'h13572468,1, 0,0,11,32'h8001F00F,1));
        vq.push_back(mk(0,0,0, 0,32'h0,        0,0,0,32'h0,0, 1,1,12,32'h13572468,0));
        vq.push_back(mk(0,0,0, 0,32'h0,        0,0,0,32'h0,0, 1,0,12,32'h13572468,0));

        idle_inputs();
        rst_i = 1;
        repeat (3) next_cycle();

        for (int i = 0; i < vq.size(); i++) begin
            if (i != 0) next_cycle();
            rst_i          = 0;
            flush_i        = vq[i].flush;
            in_valid_i     = vq[i].valid;
            in_wen_i       = vq[i].wen;
            in_waddr_i     = vq[i].waddr;
            in_alu_res_i   = vq[i].alu;
            in_is_load_i   = vq[i].is_load;
            in_load_type_i = vq[i].ltype;
            in_addr_lo_i   = vq[i].alo;
            dmem_rdata_i   = vq[i].rdata;
            dmem_data_ok_i = vq[i].dok;
            #2;
            chk_out("vec", i, vq[i].e_rdy, vq[i].e_we, vq[i].e_wa, vq[i].e_wd, vq[i].e_pend);
        end

        // Flush in WAIT, response two cycles later.
        next_cycle(); load_instr(13, 3'd4, 2'd0);                 #2;
        chk_out("flw_acc", 0, 1, 0, 12, 32'h13572468, 0);
        next_cycle(); idle_inputs(); flush_i = 1;                 #2;
        chk_out("flw_wait", 1, 0, 0, 12, 32'h13572468, 1);
        next_cycle(); idle_inputs(); in_valid_i = 1; in_wen_i = 1; in_waddr_i = 20; #2;
        chk_out("flw_drain", 2, 0, 0, 12, 32'h13572468, 0);
        next_cycle(); idle_inputs(); dmem_data_ok_i = 1; dmem_rdata_i = 32'hAAAA5555; #2;
        chk_out("flw_dok", 3, 0, 0, 12, 32'h13572468, 0);
        next_cycle(); idle_inputs();                              #2;
        chk_out("flw_idle", 4, 1, 0, 12, 32'h13572468, 0);

        // Flush and response in the same cycle.
        next_cycle(); load_instr(14, 3'd4, 2'd0);                 #2;
        chk_out("fld_acc", 0, 1, 0, 12, 32'h13572468, 0);
        next_cycle(); idle_inputs(); flush_i = 1; dmem_data_ok_i = 1; dmem_rdata_i = 32'h5A5A5A5A; #2;
        chk_out("fld_wait", 1, 0, 0, 12, 32'h13572468, 1);
        next_cycle(); idle_inputs();                              #2;
        chk_out("fld_idle", 2, 1, 0, 12, 32'h13572468, 0);
        next_cycle(); idle_inputs();                              #2;
        chk_out("fld_after", 3, 1, 0, 12, 32'h13572468, 0);

        // Flush during WB: write completes, new instruction refused.
        next_cycle(); idle_inputs(); in_valid_i = 1; in_wen_i = 1; in_waddr_i = 15; in_alu_res_i = 32'hCAFE; #2;
        chk_out("fwb_acc", 0, 1, 0, 12, 32'h13572468, 0);
        next_cycle(); idle_inputs(); flush_i = 1; in_valid_i = 1; in_wen_i = 1; in_waddr_i = 16; in_alu_res_i = 32'hBEEF; #2;
        chk_out("fwb_wb", 1, 0, 1, 15, 32'h0000CAFE, 0);
        next_cycle(); idle_inputs();                              #2;
        chk_out("fwb_idle", 2, 1, 0, 15, 32'h0000CAFE, 0);

        // Reset while waiting on a load; the late response must be ignored.
        next_cycle(); load_instr(17, 3'd0, 2'd1);                 #2;
        chk_out("rst_acc", 0, 1, 0, 15, 32'h0000CAFE, 0);
        next_cycle(); idle_inputs(); rst_i = 1;                   #2;
        chk_out("rst_wait", 1, 0, 0, 15, 32'h0000CAFE, 1);
        next_cycle(); idle_inputs(); rst_i = 0; dmem_data_ok_i = 1; dmem_rdata_i = 32'h7F7F7F7F; #2;
        chk_out("rst_clr", 2, 1, 0, 0, 32'h0, 0);
        next_cycle(); idle_inputs();                              #2;
        chk_out("rst_ign", 3, 1, 0, 0, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Writeback stage that sits directly upstream of the register file and drives its write port (we / waddr / wdata).
- Accepts one retiring instruction per handshake from the MEM stage.
- For loads, waits for the data-memory response, then aligns and extends the returned word.
- Issues exactly one register-file write per accepted instruction.
- Exposes a load-pending indication to the hazard unit.

Parameters:
DW, 32, datapath width (fixed 32; MIPS32)
AW, 5, register address width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset; synchronous, active-high
flush_i  in  1  pipeline flush (exception/eret)
in_valid_i  in  1  MEM stage presents an instruction
in_ready_o  out  1  stage can accept this cycle
in_wen_i  in  1  instruction writes a GPR
in_waddr_i  in  5  destination register
in_alu_res_i  in  32  ALU/non-load result
in_is_load_i  in  1  instruction is a load
in_load_type_i  in  3  0=LB 1=LBU 2=LH 3=LHU 4=LW; 5-7 treated as LW
in_addr_lo_i  in  2  effective address [1:0]
dmem_rdata_i  in  32  data memory read data
dmem_data_ok_i  in  1  read data valid, one-cycle pulse
rf_we_o  out  1  register file write enable
rf_waddr_o  out  5  register file write address
rf_wdata_o  out  32  register file write data
load_pending_o  out  1  load outstanding (hazard unit stalls dependents)

Behaviour:
- States: IDLE, WAIT, WB, DRAIN. Reset to IDLE. On reset, all outputs are 0 and held registers are cleared.
- in_ready_o = (state==IDLE || state==WB) && !flush_i. It is combinational from state and flush_i.
- Accept = in_valid_i && in_ready_o. On accept, latch wen, waddr, alu_res, is_load, load_type, addr_lo.
  - Non-load: next state is WB.
  - Load: next state is WAIT.
- WAIT:
  - dmem_data_ok_i && !flush_i: latch aligned data; next state WB.
  - flush_i && dmem_data_ok_i: discard the data; next state IDLE.
  - flush_i without data_ok: next state DRAIN.
  - Otherwise stay in WAIT.
- DRAIN: in_ready_o=0. Stay until dmem_data_ok_i, discard the data, then go to IDLE.
- WB lasts exactly one cycle:
  - rf_we_o = held wen && (held waddr != 0). rf_waddr_o = held waddr. rf_wdata_o = held result.
  - Next state: on accept, WB (non-load) or WAIT (load); otherwise IDLE. This gives back-to-back throughput of 1/cycle for non-loads.
- Outside WB: rf_we_o = 0. rf_waddr_o and rf_wdata_o hold their last values.
- A flush arriving while in WB does not cancel the write in progress (the instruction is committed). The flush only blocks acceptance that cycle.
- dmem_data_ok_i is ignored in IDLE and WB.
- load_pending_o = (state==WAIT). It is not asserted in DRAIN.
- Latency:
  - Non-load accepted at cycle N: rf_we_o asserted at N+1.
  - Load: rf_we_o asserted the cycle after data_ok is seen in WAIT. The earliest data_ok is N+1, giving a write at N+2.
- Alignment (b = in_addr_lo_i, s = in_addr_lo_i[1]):
  - LB: sign-extend rdata[8b+7:8b].
  - LBU: zero-extend rdata[8b+7:8b].
  - LH: sign-extend rdata[16s+15:16s].
  - LHU: zero-extend rdata[16s+15:16s].
  - LW: rdata unchanged.
  - Misalignment is not checked here; it is trapped upstream.
- Reset mid-operation: any state goes to IDLE on the next edge and the pending response is dropped. The memory side is reset on the same rst_i.

Test Plan:
- Non-load, wen=1, waddr=5, alu_res=0x12345678, accepted at cycle 2 -> rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x12345678 at cycle 3 only.
- Four back-to-back non-loads to regs 1..4 -> in_ready_o stays 1 and rf_we_o is high for 4 consecutive cycles in order. waddr=0 with wen=1 -> rf_we_o=0.
- LB, addr_lo=3, rdata=0x80FF00AA, data_ok 3 cycles after accept -> load_pending_o=1 for 3 cycles, in_ready_o=0, then wdata=0xFFFFFF80. Repeat with LBU -> 0x00000080.
- LH addr_lo=2 and LHU addr_lo=0, rdata=0x8001F00F -> 0xFFFF8001 and 0x0000F00F respectively. LW -> 0x8001F00F.
- Flush in WAIT, data_ok 2 cycles later -> no rf_we_o, in_ready_o=0 until the data_ok cycle passes, then IDLE. Repeat with flush and data_ok in the same cycle -> discarded, IDLE next cycle.
- Flush during WB with in_valid_i=1 -> the current write still occurs and the new instruction is not accepted. rst_i asserted in WAIT -> IDLE, all outputs 0 next cycle, and a later data_ok is ignored.
